// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the fetch/decode stage and the ALU datapath.
// ALU select encodings must match the alu block exactly.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } fd_state_t;

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction-memory port: request (valid/ready + address) and response (valid + data).
interface fetch_decode_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/rtype_decoder.sv
// Combinational RV32I R-type decoder: register fields, ALU select and legality.
// Anything outside the supported ALU subset is flagged illegal with alu_control = ALU_AND.
module rtype_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  alu_control,
    output logic        legal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        legal       = 1'b0;
        alu_control = ALU_AND;
        if (opcode == OP_RTYPE) begin
            unique case ({funct7, funct3})
                {F7_BASE, F3_ADD_SUB}: begin legal = 1'b1; alu_control = ALU_ADD; end
                {F7_ALT,  F3_ADD_SUB}: begin legal = 1'b1; alu_control = ALU_SUB; end
                {F7_BASE, F3_AND}:     begin legal = 1'b1; alu_control = ALU_AND; end
                {F7_BASE, F3_OR}:      begin legal = 1'b1; alu_control = ALU_OR;  end
                {F7_BASE, F3_SLT}:     begin legal = 1'b1; alu_control = ALU_SLT; end
                {F7_BASE, F3_XOR}:     begin legal = 1'b1; alu_control = ALU_XOR; end
                default:               begin legal = 1'b0; alu_control = ALU_AND; end
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode control stage: fetches one instruction at a time, decodes R-type ALU ops,
// advances the PC, counts retirements and halts permanently on an unsupported encoding.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_FETCH   | request pc from imem while run is high; leave on acceptance
// ST_WAIT    | request accepted, waiting for the response word
// ST_EXECUTE | one cycle: decoded fields drive the datapath, then retire or halt
// ST_HALT    | illegal instruction seen; frozen until reset
module fetch_decode
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    fetch_decode_if.master    imem,
    output logic [4:0]        read_reg1,
    output logic [4:0]        read_reg2,
    output logic [4:0]        write_reg,
    output logic [2:0]        alu_control,
    output logic              write_on_register,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       retired_count
);

    fd_state_t   state_q;
    fd_state_t   state_d;
    logic [31:0] instr_q;
    logic        dec_legal;
    logic        req_valid;
    logic        wr_en;

    // Decoding straight from the held instruction keeps the fields stable outside EXECUTE.
    rtype_decoder u_decoder (
        .instr       (instr_q),
        .rs1         (read_reg1),
        .rs2         (read_reg2),
        .rd          (write_reg),
        .alu_control (alu_control),
        .legal       (dec_legal)
    );

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc;
    assign write_on_register   = wr_en;

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                req_valid = run;
                if (run && imem.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                wr_en   = dec_legal && (write_reg != 5'd0);
                state_d = dec_legal ? ST_FETCH : ST_HALT;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // Reset must silence the bus and the write strobe in the very cycle it is asserted.
        if (reset) begin
            req_valid = 1'b0;
            wr_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc            <= RESET_PC;
            instr_q       <= 32'd0;
            halted        <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WAIT && imem.imem_rsp_valid) begin
                instr_q <= imem.imem_rsp_data;
            end
            if (state_q == ST_EXECUTE) begin
                if (dec_legal) begin
                    pc            <= pc + ADDR_W'(4);
                    retired_count <= retired_count + 32'd1;
                end else begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Upstream control stage for the register-block/ALU datapath.
- Fetches 32-bit RV32I instructions from an instruction-memory port over a valid/ready handshake and decodes R-type ALU instructions.
- Drives the datapath's register addresses, ALU control and register write enable.
- Maintains the PC, halts on any unsupported encoding, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; must be a multiple of 4.
- ADDR_W, 32, PC / imem address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; sampled only in FETCH.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  ADDR_W  fetch address (= pc).
- imem_rsp_valid  input  1  instruction data valid.
- imem_rsp_data  input  32  fetched instruction word.
- read_reg1  output  5  rs1 field to datapath.
- read_reg2  output  5  rs2 field to datapath.
- write_reg  output  5  rd field to datapath.
- alu_control  output  3  ALU operation select.
- write_on_register  output  1  register write enable, 1-cycle pulse.
- pc  output  ADDR_W  current PC.
- halted  output  1  sticky illegal-instruction halt.
- retired_count  output  32  number of instructions executed.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=FETCH, pc=RESET_PC, instr register=0.
  - read_reg1, read_reg2, write_reg, alu_control = 0.
  - write_on_register=0, halted=0, retired_count=0, imem_req_valid=0 in the cycle reset is asserted.
- Instruction memory must share reset and drop any outstanding request. Reset mid-WAIT discards the in-flight fetch.
- FSM states: FETCH, WAIT, EXECUTE, HALT.
- FETCH:
  - imem_req_valid = run, imem_addr = pc.
  - Request accepted when valid && ready → WAIT. Otherwise stay.
  - imem_rsp_valid is ignored in FETCH.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid, capture imem_rsp_data → EXECUTE. Otherwise stay; no timeout.
- EXECUTE (exactly 1 cycle):
  - Decoded fields are registered from the captured instruction and valid throughout this cycle.
  - Legal instruction: pc ← pc+4 (mod 2^ADDR_W; 0xFFFF_FFFC wraps to 0), retired_count ← retired_count+1 (wraps), → FETCH.
  - Illegal instruction: write_on_register=0, pc unchanged (points at offending instruction), halted←1, → HALT.
- HALT: absorbing; no requests, outputs frozen; only reset exits.
- Legal set (opcode 7'b0110011), keyed on funct7/funct3 → alu_control:
  - ADD: 0000000 / 000 → 3'b010
  - SUB: 0100000 / 000 → 3'b110
  - AND: 0000000 / 111 → 3'b000
  - OR: 0000000 / 110 → 3'b001
  - SLT: 0000000 / 010 → 3'b111
  - XOR: 0000000 / 100 → 3'b011
  - Every other opcode/funct combination is illegal.
- write_on_register:
  - High only in the EXECUTE cycle of a legal instruction, and only when rd != 0.
  - rd == x0 still retires and counts.
- read_reg1, read_reg2, write_reg, alu_control hold their last decoded values outside EXECUTE.
- Throughput: minimum 3 cycles per instruction (FETCH accept, WAIT with 1-cycle response, EXECUTE).
- run deasserted in FETCH stalls with req_valid=0. run is ignored in WAIT and EXECUTE; an accepted fetch always completes.

Decomposition:
- Shared package (riscv_pkg):
  - Opcode constant OP_RTYPE.
  - funct3/funct7 constants.
  - alu_control encodings ALU_AND/OR/ADD/XOR/SUB/SLT; the alu block uses the same constants.
  - FSM state enum.
- One natural sub-module: rtype_decoder, combinational.
  - In: instr[31:0].
  - Out: rs1, rs2, rd, alu_control, legal.
- FSM, PC and counter stay in fetch_decode.

Test Plan:
1. Reset then run=1, ready=1, rsp one cycle later, instr 0x002081B3 (add x3,x1,x2) → imem_addr=0; in EXECUTE: read_reg1=1, read_reg2=2, write_reg=3, alu_control=3'b010, write_on_register=1 for exactly 1 cycle; then pc=4, retired_count=1.
2. Stream sub/and/or/slt/xor (0x40208133, 0x0020F1B3, 0x0020E1B3, 0x0020A1B3, 0x0020C1B3) → alu_control 110, 000, 001, 111, 011 in order; addresses 0,4,8,12,16; 3 cycles per instruction.
3. Backpressure: ready=0 for 4 cycles, then rsp delayed 5 cycles → req_valid and addr stable while stalled; no write pulse until EXECUTE; pc unchanged until retire.
4. Instr 0x00208033 (rd=x0) → write_on_register stays 0, retired_count increments. Then instr 0x00000013 (addi) → halted=1, pc holds the addi address, no further imem_req_valid until reset.
5. RESET_PC=32'hFFFF_FFFC, one legal instruction → pc wraps to 0 and the next fetch address is 0.
6. Assert reset during WAIT, then return an rsp → state returns to FETCH, pc=RESET_PC, and the stale response is ignored with no write pulse; run=0 after reset keeps req_valid=0.
